// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - two-operand key-driven calculator sequencer
module calc_key_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [8:0]  last_change,
    output logic [1:0]  state,
    output logic [6:0]  operand_a,
    output logic [6:0]  operand_b,
    output logic [1:0]  op,
    output logic [13:0] result,
    output logic        result_neg,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_A_ENTRY = 2'd0;
    localparam logic [1:0] ST_B_ENTRY = 2'd1;
    localparam logic [1:0] ST_CALC    = 2'd2;
    localparam logic [1:0] ST_RESULT  = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [8:0] KEY_ADD   = 9'h079;
    localparam logic [8:0] KEY_SUB   = 9'h07B;
    localparam logic [8:0] KEY_MUL   = 9'h03A;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_CLEAR = 9'h066;

    logic [1:0]  state_q, state_d;
    logic [6:0]  a_q, a_d;
    logic [6:0]  b_q, b_d;
    logic [1:0]  a_cnt_q, a_cnt_d;
    logic [1:0]  b_cnt_q, b_cnt_d;
    logic [1:0]  op_q, op_d;
    logic [13:0] result_q, result_d;
    logic        neg_q, neg_d;
    logic        done_q, done_d;
    logic [13:0] acc_q, acc_d;
    logic [2:0]  iter_q, iter_d;

    // Key decode: digit value, and operator class with its encoding
    logic        is_digit;
    logic [3:0]  digit;
    logic        is_oper;
    logic [1:0]  oper;
    logic        is_enter;
    logic        is_clear;

    // Decode the scan code into digit / operator / enter / clear classes
    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (last_change)
            9'h070: digit = 4'd0;
            9'h069: digit = 4'd1;
            9'h072: digit = 4'd2;
            9'h07A: digit = 4'd3;
            9'h06B: digit = 4'd4;
            9'h073: digit = 4'd5;
            9'h074: digit = 4'd6;
            9'h06C: digit = 4'd7;
            9'h075: digit = 4'd8;
            9'h07D: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
        is_oper = 1'b1;
        oper    = OP_ADD;
        case (last_change)
            KEY_ADD: oper = OP_ADD;
            KEY_SUB: oper = OP_SUB;
            KEY_MUL: oper = OP_MUL;
            default: is_oper = 1'b0;
        endcase
        is_enter = (last_change == KEY_ENTER);
        is_clear = (last_change == KEY_CLEAR);
    end

    // Decimal accumulate; counts cap at 2 so the operands stay within 0..99
    logic [6:0]  a_shifted;
    logic [6:0]  b_shifted;
    assign a_shifted = (a_q << 3) + (a_q << 1) + {3'd0, digit};
    assign b_shifted = (b_q << 3) + (b_q << 1) + {3'd0, digit};

    // Shift-add partial product for the current multiply iteration
    logic [13:0] partial;
    assign partial = b_q[iter_q] ? ({7'd0, a_q} << iter_q) : 14'd0;

    // Next-state logic for the sequencer and its datapath registers
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        a_cnt_d  = a_cnt_q;
        b_cnt_d  = b_cnt_q;
        op_d     = op_q;
        result_d = result_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        iter_d   = iter_q;

        if (state_q == ST_CALC) begin
            // Keys are ignored here; the arithmetic runs to completion
            case (op_q)
                OP_SUB: begin
                    if (a_q >= b_q) begin
                        result_d = {7'd0, a_q - b_q};
                        neg_d    = 1'b0;
                    end else begin
                        result_d = {7'd0, b_q - a_q};
                        neg_d    = 1'b1;
                    end
                    state_d = ST_RESULT;
                    done_d  = 1'b1;
                end
                OP_MUL: begin
                    acc_d = acc_q + partial;
                    if (iter_q == 3'd6) begin
                        result_d = acc_q + partial;
                        neg_d    = 1'b0;
                        acc_d    = 14'd0;
                        iter_d   = 3'd0;
                        state_d  = ST_RESULT;
                        done_d   = 1'b1;
                    end else begin
                        iter_d = iter_q + 3'd1;
                    end
                end
                default: begin
                    result_d = {7'd0, a_q} + {7'd0, b_q};
                    neg_d    = 1'b0;
                    state_d  = ST_RESULT;
                    done_d   = 1'b1;
                end
            endcase
        end else if (key_valid) begin
            if (is_clear) begin
                state_d  = ST_A_ENTRY;
                a_d      = 7'd0;
                b_d      = 7'd0;
                a_cnt_d  = 2'd0;
                b_cnt_d  = 2'd0;
                op_d     = OP_ADD;
                result_d = 14'd0;
                neg_d    = 1'b0;
            end else begin
                case (state_q)
                    ST_A_ENTRY: begin
                        if (is_digit && a_cnt_q != 2'd2) begin
                            a_d     = a_shifted;
                            a_cnt_d = a_cnt_q + 2'd1;
                        end else if (is_oper && a_cnt_q != 2'd0) begin
                            op_d    = oper;
                            b_d     = 7'd0;
                            b_cnt_d = 2'd0;
                            state_d = ST_B_ENTRY;
                        end
                    end
                    ST_B_ENTRY: begin
                        if (is_digit && b_cnt_q != 2'd2) begin
                            b_d     = b_shifted;
                            b_cnt_d = b_cnt_q + 2'd1;
                        end else if (is_enter && b_cnt_q != 2'd0) begin
                            acc_d   = 14'd0;
                            iter_d  = 3'd0;
                            state_d = ST_CALC;
                        end
                    end
                    ST_RESULT: begin
                        if (is_digit) begin
                            a_d     = {3'd0, digit};
                            a_cnt_d = 2'd1;
                            b_d     = 7'd0;
                            b_cnt_d = 2'd0;
                            state_d = ST_A_ENTRY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers with synchronous reset taking priority over keys
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_A_ENTRY;
            a_q      <= 7'd0;
            b_q      <= 7'd0;
            a_cnt_q  <= 2'd0;
            b_cnt_q  <= 2'd0;
            op_q     <= OP_ADD;
            result_q <= 14'd0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= 14'd0;
            iter_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_cnt_q  <= a_cnt_d;
            b_cnt_q  <= b_cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            iter_q   <= iter_d;
        end
    end

    assign state      = state_q;
    assign operand_a  = a_q;
    assign operand_b  = b_q;
    assign op         = op_q;
    assign result     = result_q;
    assign result_neg = neg_q;
    assign busy       = (state_q == ST_CALC);
    assign done       = done_q;

endmodule
